// File: rtl/aes_key_sched.sv
// aes_key_sched -- iterative AES-128/AES-256 key-schedule engine.
//
// Accepts one cipher key over a valid/ready handshake and streams every
// round key (index 0..10 or 0..14), one 128-bit key per transfer. A single
// 4-byte S-box (S4, one registered cycle) is the only substitution resource,
// so each derived key costs SUB + CALC + EMIT = 3 cycles when unstalled.
//
// Optional build macro: AES_KS_ABORT_EN adds the `abort` input, which drops
// any schedule in flight and returns the engine to IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   key_in     cipher key; word 0 at [255:224]; 128 mode uses [255:128]
//   key_valid  key offered
//   key_ready  engine idle, key will be taken
//   rk_data    round key, word 0 at [127:96]
//   rk_index   round number of rk_data
//   rk_last    final round key of the schedule
//   rk_valid   round key offered
//   rk_ready   consumer accepts round key
//   abort      (AES_KS_ABORT_EN only) cancel the schedule in flight

// One S-box byte lane, registered output.
module sbox_byte (
  input  logic       clk,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_ff @(posedge clk) dout <= SBOX[din];
endmodule

// Four S-box lanes: SubWord with one cycle of latency.
module S4 (
  input  logic        clk,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar g = 0; g < 4; g++) begin : g_lane
    sbox_byte u_sb (
      .clk  (clk),
      .din  (din[8*g +: 8]),
      .dout (dout[8*g +: 8])
    );
  end
endmodule

module aes_key_sched #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready
`ifdef AES_KS_ABORT_EN
  ,
  input  logic         abort
`endif
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_sched: KEY_BITS must be 128 or 256");
  end

  localparam bit         K256     = (KEY_BITS == 256);
  localparam logic [3:0] LAST_IDX = K256 ? 4'd14 : 4'd10;

  typedef enum logic [1:0] {IDLE, EMIT, SUB, CALC} state_t;

  state_t       state_q, state_d;
  logic [127:0] a_q;      // key two back (256 mode); holds key low half until index 1
  logic [7:0]   rcon_q;
  logic         abort_w;

`ifdef AES_KS_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign rk_last   = (rk_index == LAST_IDX);

  // In SUB/CALC rk_index is still the key just transferred. Next index even
  // (current odd) takes RotWord + rcon in 256 mode; 128 mode always does.
  logic        step_full;
  logic [31:0] b3, s4_in, s4_out, t;
  logic [127:0] x;
  logic [31:0] c0, c1, c2, c3;

  assign step_full = !K256 || rk_index[0];
  assign b3        = rk_data[31:0];
  assign s4_in     = step_full ? {b3[23:0], b3[31:24]} : b3;

  S4 u_s4 (
    .clk  (clk),
    .din  (s4_in),
    .dout (s4_out)
  );

  assign t  = s4_out ^ (step_full ? {rcon_q, 24'h0} : 32'h0);
  assign x  = K256 ? a_q : rk_data;
  assign c0 = x[127:96] ^ t;
  assign c1 = x[95:64]  ^ c0;
  assign c2 = x[63:32]  ^ c1;
  assign c3 = x[31:0]   ^ c2;

  // State register
  always_ff @(posedge clk) begin
    if (rst || abort_w) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_valid) state_d = EMIT;
      EMIT: if (rk_ready) begin
        if (rk_last)                          state_d = IDLE;
        else if (K256 && rk_index == 4'd0)    state_d = EMIT;
        else                                  state_d = SUB;
      end
      SUB:     state_d = CALC;
      CALC:    state_d = EMIT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst || abort_w) begin
      rk_data  <= '0;
      rk_index <= '0;
      a_q      <= '0;
      rcon_q   <= 8'h01;
    end else begin
      case (state_q)
        IDLE: if (key_valid) begin
          rk_data  <= key_in[255:128];
          a_q      <= key_in[127:0];
          rk_index <= 4'd0;
          rcon_q   <= 8'h01;
        end
        EMIT: if (rk_ready && !rk_last && K256 && rk_index == 4'd0) begin
          // 256 mode: second half of the cipher key is round key 1 as-is
          rk_data  <= a_q;
          a_q      <= rk_data;
          rk_index <= 4'd1;
        end
        CALC: begin
          rk_data  <= {c0, c1, c2, c3};
          a_q      <= rk_data;
          rk_index <= rk_index + 4'd1;
          if (step_full) rcon_q <= xtime(rcon_q);
        end
        default: ;
      endcase
    end
  end

endmodule
